// File: rtl/fetch_unit_pkg.sv
// Types and helpers shared by the fetch unit and its instruction buffer.
`ifndef COPPERV_H
`include "copperv_h.sv"
`endif
package fetch_unit_pkg;
  localparam int PC_W   = `PC_WIDTH;
  localparam int INST_W = `INST_WIDTH;
  localparam logic [PC_W-1:0] PC_INC = `PC_INC;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(3);
  endfunction
endpackage

// File: rtl/copperv_h.sv
// Shared copperv header: datapath widths and fetch defaults.
// Guarded so every file may pull it in without redefinition.
`ifndef COPPERV_H
`define COPPERV_H
`define INST_WIDTH 32
`define PC_WIDTH 32
`define PC_INIT_DEFAULT 32'h0000_0000
`define PC_INC 4
`endif

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs; flush wins over push/pop.
`ifndef COPPERV_H
`include "copperv_h.sv"
`endif
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wr_entry,
  output fetch_entry_t     rd_entry,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  fetch_entry_t     mem_q [DEPTH];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !flush && !empty;
    do_push  = push && !flush && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_entry;
  end
endmodule

// File: rtl/fetch_unit.sv
// copperv instruction fetch: owns the fetch PC, issues credit-limited word
// requests, buffers responses and handles redirects by discarding stale words.
`ifndef COPPERV_H
`include "copperv_h.sv"
`endif
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [`PC_WIDTH-1:0] PC_INIT   = `PC_INIT_DEFAULT,
  parameter int                   BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ir_addr_valid,
  input  logic                   ir_addr_ready,
  output logic [`PC_WIDTH-1:0]   ir_addr,
  input  logic                   ir_data_valid,
  output logic                   ir_data_ready,
  input  logic [`INST_WIDTH-1:0] ir_data,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [`INST_WIDTH-1:0] inst,
  output logic [`PC_WIDTH-1:0]   inst_pc,
  input  logic                   pc_load,
  input  logic [`PC_WIDTH-1:0]   pc_next
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W:0]   credits_used;
  logic             buf_empty, buf_full;
  logic             buf_push, buf_pop;
  logic             addr_hs, resp_dec;
  fetch_entry_t     wr_entry, rd_entry;

  assign credits_used  = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign ir_addr_valid = !rst && !pc_load && !buf_full
                         && (credits_used < (CNT_W + 1)'(BUF_DEPTH));
  assign ir_addr       = fetch_pc_q;
  assign ir_data_ready = 1'b1;
  assign addr_hs       = ir_addr_valid && ir_addr_ready;

  assign inst_valid = !buf_empty;
  assign inst       = rd_entry.inst;
  assign inst_pc    = rd_entry.pc;
  assign wr_entry   = '{pc: resp_pc_q, inst: ir_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    // A response with nothing outstanding is stale from before reset; never underflow.
    resp_dec      = ir_data_valid && (outstanding_q != '0);
    if (addr_hs && !resp_dec)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!addr_hs && resp_dec) outstanding_d = outstanding_q - CNT_W'(1);
    if (pc_load) begin
      fetch_pc_d = word_align(pc_next);
      resp_pc_d  = word_align(pc_next);
      discard_d  = outstanding_d;
    end else begin
      if (addr_hs) fetch_pc_d = fetch_pc_q + PC_INC;
      if (ir_data_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CNT_W'(1);
        end else begin
          buf_push  = 1'b1;
          resp_pc_d = resp_pc_q + PC_INC;
        end
      end
      buf_pop = inst_valid && inst_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= PC_INIT;
      resp_pc_q     <= PC_INIT;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .pop      (buf_pop),
    .flush    (pc_load),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .count    (buf_count),
    .empty    (buf_empty),
    .full     (buf_full)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirects, PC wrap.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_addr_valid, ir_addr_ready = 1'b1;
  logic [31:0] ir_addr;
  logic        ir_data_valid = 1'b0, ir_data_ready;
  logic [31:0] ir_data = '0;
  logic        inst_valid, inst_ready = 1'b1;
  logic [31:0] inst, inst_pc;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = '0;

  logic        w_addr_valid, w_addr_ready = 1'b1;
  logic [31:0] w_addr;
  logic        w_data_valid = 1'b0, w_data_ready;
  logic [31:0] w_data = '0;
  logic        w_inst_valid, w_inst_ready = 1'b1;
  logic [31:0] w_inst, w_inst_pc;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          mem_en = 1'b1;
  logic [31:0] mq[$], wq[$], acc[$], del_pc[$], del_inst[$];

  always #5 clk = ~clk;

  fetch_unit #(.PC_INIT(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .pc_load(pc_load), .pc_next(pc_next)
  );

  fetch_unit #(.PC_INIT(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_w (
    .clk(clk), .rst(rst),
    .ir_addr_valid(w_addr_valid), .ir_addr_ready(w_addr_ready), .ir_addr(w_addr),
    .ir_data_valid(w_data_valid), .ir_data_ready(w_data_ready), .ir_data(w_data),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
    .pc_load(1'b0), .pc_next(32'h0000_0000)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0020_0113;
    return (a << 8) | 32'h13;
  endfunction

  // One clock: capture handshakes, cross the edge, then drive the next memory responses.
  task automatic tick();
    logic        hs, whs, rst_e, ovf;
    logic [31:0] a, wa;
    hs    = ir_addr_valid && ir_addr_ready;
    a     = ir_addr;
    whs   = w_addr_valid && w_addr_ready;
    wa    = w_addr;
    rst_e = rst;
    ovf   = dut.u_buf.push && dut.u_buf.full && !dut.u_buf.pop && !dut.u_buf.flush;
    check("no_overflow", 32'(ovf), 32'd0);
    if (inst_valid && inst_ready) begin
      del_pc.push_back(inst_pc);
      del_inst.push_back(inst);
    end
    @(posedge clk);
    #1;
    if (rst_e) begin
      mq.delete();
      wq.delete();
      ir_data_valid = ~ir_data_valid;
      ir_data       = 32'hDEAD_BEEF;
      w_data_valid  = ~w_data_valid;
      w_data        = 32'hDEAD_BEEF;
    end else begin
      if (hs) begin
        mq.push_back(a);
        acc.push_back(a);
      end
      if (whs) wq.push_back(wa);
      if (mem_en && mq.size() > 0) begin
        ir_data_valid = 1'b1;
        ir_data       = mem_word(mq.pop_front());
      end else begin
        ir_data_valid = 1'b0;
      end
      if (wq.size() > 0) begin
        w_data_valid = 1'b1;
        w_data       = mem_word(wq.pop_front());
      end else begin
        w_data_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pc_load = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    ir_data_valid = 1'b0;
    w_data_valid  = 1'b0;
    mem_en = 1'b1;
    acc.delete();
    del_pc.delete();
    del_inst.delete();
    #1;
  endtask

  initial begin
    // Reset held three cycles with responses toggling
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_addr_valid", 32'(ir_addr_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_data_ready", 32'(ir_data_ready), 32'd1);
    end
    rst = 1'b0;
    ir_data_valid = 1'b0;
    w_data_valid  = 1'b0;
    acc.delete();
    del_pc.delete();
    del_inst.delete();
    #1;
    check("first_addr_valid", 32'(ir_addr_valid), 32'd1);
    check("first_addr", ir_addr, 32'h0);
    check("first_inst_valid", 32'(inst_valid), 32'd0);

    // Streaming
    tick();
    check("s_c1_addr", ir_addr, 32'h4);
    check("s_c1_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    check("s_c2_inst_valid", 32'(inst_valid), 32'd1);
    check("s_c2_inst", inst, 32'h0010_0093);
    check("s_c2_pc", inst_pc, 32'h0);
    check("s_c2_addr_valid", 32'(ir_addr_valid), 32'd0);
    tick();
    check("s_c3_inst", inst, 32'h0020_0113);
    check("s_c3_pc", inst_pc, 32'h4);
    check("s_c3_addr", ir_addr, 32'h8);
    tick();
    check("s_c4_inst_valid", 32'(inst_valid), 32'd0);
    repeat (3) tick();
    check("s_del_count", 32'(del_pc.size()), 32'd4);
    if (del_pc.size() == 4) begin
      check("s_del0_pc", del_pc[0], 32'h0);
      check("s_del0_inst", del_inst[0], 32'h0010_0093);
      check("s_del1_pc", del_pc[1], 32'h4);
      check("s_del1_inst", del_inst[1], 32'h0020_0113);
      check("s_del2_pc", del_pc[2], 32'h8);
      check("s_del2_inst", del_inst[2], 32'h0000_0813);
      check("s_del3_pc", del_pc[3], 32'hC);
      check("s_del3_inst", del_inst[3], 32'h0000_0C13);
    end

    // Backpressure
    do_reset();
    inst_ready = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 7; i++) begin
      check("bp_inst_stable", inst, 32'h0010_0093);
      tick();
    end
    check("bp_req_count", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) begin
      check("bp_req0", acc[0], 32'h0);
      check("bp_req1", acc[1], 32'h4);
    end
    check("bp_addr_valid", 32'(ir_addr_valid), 32'd0);
    check("bp_inst_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    #1;
    tick();
    check("bp_rel_addr_valid", 32'(ir_addr_valid), 32'd1);
    check("bp_rel_addr", ir_addr, 32'h8);
    check("bp_rel_pc", inst_pc, 32'h4);

    // Redirect with two requests in flight
    do_reset();
    mem_en = 1'b0;
    tick();
    tick();
    check("r2_full_credit", 32'(ir_addr_valid), 32'd0);
    pc_load = 1'b1;
    pc_next = 32'h0000_0103;
    mem_en  = 1'b1;
    #1;
    tick();
    pc_load = 1'b0;
    #1;
    check("r2_inst_valid_after", 32'(inst_valid), 32'd0);
    check("r2_c3_addr_valid", 32'(ir_addr_valid), 32'd0);
    tick();
    check("r2_c4_addr_valid", 32'(ir_addr_valid), 32'd1);
    check("r2_c4_addr", ir_addr, 32'h100);
    tick();
    check("r2_c5_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    check("r2_c6_inst_valid", 32'(inst_valid), 32'd1);
    check("r2_c6_pc", inst_pc, 32'h100);
    check("r2_c6_inst", inst, 32'h0001_0013);
    check("r2_no_stale", 32'(del_pc.size()), 32'd0);

    // Redirect in the same cycle as a response
    do_reset();
    mem_en = 1'b0;
    tick();
    tick();
    mem_en = 1'b1;
    tick();
    check("rs_resp_present", 32'(ir_data_valid), 32'd1);
    pc_load = 1'b1;
    pc_next = 32'h0000_0200;
    #1;
    tick();
    pc_load = 1'b0;
    #1;
    check("rs_inst_valid_after", 32'(inst_valid), 32'd0);
    check("rs_addr_valid", 32'(ir_addr_valid), 32'd1);
    check("rs_addr", ir_addr, 32'h200);
    tick();
    check("rs_c5_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    check("rs_c6_inst_valid", 32'(inst_valid), 32'd1);
    check("rs_c6_pc", inst_pc, 32'h200);
    check("rs_c6_inst", inst, 32'h0002_0013);
    check("rs_no_stale", 32'(del_pc.size()), 32'd0);

    // PC wrap-around on the PC_INIT=0xFFFFFFFC instance
    do_reset();
    check("w_c0_addr_valid", 32'(w_addr_valid), 32'd1);
    check("w_c0_addr", w_addr, 32'hFFFF_FFFC);
    tick();
    check("w_c1_addr", w_addr, 32'h0);
    tick();
    check("w_c2_inst_valid", 32'(w_inst_valid), 32'd1);
    check("w_c2_pc", w_inst_pc, 32'hFFFF_FFFC);
    check("w_c2_inst", w_inst, 32'hFFFF_FC13);
    tick();
    check("w_c3_pc", w_inst_pc, 32'h0);
    check("w_c3_inst", w_inst, 32'h0010_0093);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
